// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stop levels, stall-vector
// encodings, sequencer state codes and the control bus carried by the
// stall priority encoder.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W_DEF = 6;
  localparam int CNT_W_DEF   = 6;

  // Per-stage stall level: 1 stops the pipeline register of that stage.
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Reset is active-high.
  localparam logic RST_ENABLE = 1'b1;

  // Stall vectors, bit i = stage i (0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb).
  // Each request freezes its own stage and everything upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    CTRL_IDLE  = 1'b0,
    CTRL_MULTI = 1'b1
  } ctrl_state_e;

  // Control bus produced by the stall priority encoder.
  typedef struct packed {
    logic [5:0] stall;
    logic       flush;
  } ctrl_bus_t;

endpackage

// File: rtl/pipe_stall_ctrl_counter.sv
// multi_cycle_counter: remaining-cycle counter for multi-cycle EX operations.
// Clear beats load, load beats decrement; otherwise the value holds.
module multi_cycle_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register: clear / load / decrement / hold.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Arbitrates id/ex/mem stall requests and flush, and sequences multi-cycle
// EX operations. All outputs are combinational from registered state and the
// current inputs, and forced to zero while rst is high.
// Optional build macro STALL_PERF_EN adds stall/flush performance counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STALL_W = STALL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_id,
  input  logic               stallreq_from_ex,
  input  logic               stallreq_from_mem,
  input  logic               flush_req,
  input  logic               ex_multi_start,
  input  logic [CNT_W-1:0]   ex_multi_cycles,
`ifdef STALL_PERF_EN
  input  logic               perf_clr,
  output logic [31:0]        perf_stall_cycles,
  output logic [15:0]        perf_flush_cnt,
`endif
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               ex_busy,
  output logic               ex_multi_done,
  output logic [CNT_W-1:0]   ex_cnt
);

  ctrl_state_e      state_q, state_d;
  logic             start_long;
  logic             multi_stall;
  logic             cnt_load, cnt_dec, cnt_clr, cnt_zero;
  logic             done_raw;
  logic [CNT_W-1:0] cnt_val, cnt_view;
  ctrl_bus_t        bus;

  // An op of two or more cycles needs the sequencer; shorter ones finish at once.
  assign start_long = ex_multi_start && (ex_multi_cycles >= CNT_W'(2));

  // The counter holds cycles remaining after the current one. The start cycle
  // is EX cycle 1 and shows N-1, so the register is loaded with N-2 and
  // reaches zero exactly in EX cycle N.
  multi_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (ex_multi_cycles - CNT_W'(2)),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Multi-cycle sequencing: next state, counter controls, done and cnt view.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    state_d     = state_q;
    multi_stall = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    cnt_clr     = 1'b0;
    done_raw    = 1'b0;
    cnt_view    = '0;
    case (state_q)
      CTRL_IDLE: begin
        multi_stall = start_long;
        cnt_load    = start_long && !flush_req;
        done_raw    = ex_multi_start && !start_long;
        cnt_view    = start_long ? (ex_multi_cycles - CNT_W'(1)) : '0;
        if (cnt_load) state_d = CTRL_MULTI;
      end
      CTRL_MULTI: begin
        multi_stall = !cnt_zero;
        cnt_view    = cnt_val;
        if (flush_req) begin
          cnt_clr = 1'b1;
          state_d = CTRL_IDLE;
        end else if (stallreq_from_mem) begin
          // EX frozen by memory: counter and done hold off.
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          done_raw = 1'b1;
          state_d  = CTRL_IDLE;
        end
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) state_q <= CTRL_IDLE;
    else                   state_q <= state_d;
  end

  // Stall priority encoder: flush > mem > ex (incl. multi-cycle) > id.
  always_comb begin
    bus.stall = STALL_NONE;
    bus.flush = NOSTOP;
    if (flush_req) begin
      bus.flush = STOP;
    end else if (stallreq_from_mem) begin
      bus.stall = STALL_MEM;
    end else if (stallreq_from_ex || multi_stall) begin
      bus.stall = STALL_EX;
    end else if (stallreq_from_id) begin
      bus.stall = STALL_ID;
    end
  end

  // Outputs are combinational, so reset must mask them explicitly.
  assign stall         = rst ? '0   : STALL_W'(bus.stall);
  assign flush         = rst ? 1'b0 : bus.flush;
  assign ex_busy       = rst ? 1'b0 : (state_q == CTRL_MULTI);
  assign ex_multi_done = rst ? 1'b0 : done_raw;
  assign ex_cnt        = rst ? '0   : cnt_view;

`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  // Performance counters: synchronous clear wins, otherwise wrapping increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else if (perf_clr) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall[0]) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)    perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cnt    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl. Inputs change 1 ns after the rising
// edge; outputs are compared 2 ns later, well clear of the next edge.
module tb_pipe_stall_ctrl;

  localparam int STALL_W = 6;
  localparam int CNT_W   = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               id_r, ex_r, mem_r, fl_r, st_r;
  logic [CNT_W-1:0]   n_r;
  logic [STALL_W-1:0] stall;
  logic               flush, ex_busy, ex_multi_done;
  logic [CNT_W-1:0]   ex_cnt;
`ifdef STALL_PERF_EN
  logic               perf_clr;
  logic [31:0]        perf_stall_cycles;
  logic [15:0]        perf_flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (id_r),
    .stallreq_from_ex  (ex_r),
    .stallreq_from_mem (mem_r),
    .flush_req         (fl_r),
    .ex_multi_start    (st_r),
    .ex_multi_cycles   (n_r),
`ifdef STALL_PERF_EN
    .perf_clr          (perf_clr),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt),
`endif
    .stall             (stall),
    .flush             (flush),
    .ex_busy           (ex_busy),
    .ex_multi_done     (ex_multi_done),
    .ex_cnt            (ex_cnt)
  );

  task automatic set(input logic id, input logic ex, input logic mem,
                     input logic fl, input logic st, input int n);
    id_r = id; ex_r = ex; mem_r = mem; fl_r = fl; st_r = st; n_r = CNT_W'(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {stall, flush, busy, done, cnt} against the expected tuple.
  task automatic chk(input string tag, input logic [5:0] e_stall, input logic e_fl,
                     input logic e_busy, input logic e_done, input int e_cnt);
    logic [14:0] obs, exp;
    #2;
    obs = {stall, flush, ex_busy, ex_multi_done, ex_cnt};
    exp = {e_stall, e_fl, e_busy, e_done, CNT_W'(e_cnt)};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed stall=%b fl=%b busy=%b done=%b cnt=%0d expected stall=%b fl=%b busy=%b done=%b cnt=%0d",
             tag, obs[14:9], obs[8], obs[7], obs[6], obs[5:0],
             exp[14:9], exp[8], exp[7], exp[6], exp[5:0]);
    end
  endtask

`ifdef STALL_PERF_EN
  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    set(0, 0, 0, 0, 0, 0);
`ifdef STALL_PERF_EN
    perf_clr = 1'b0;
`endif
    // Reset: outputs forced low even with live requests.
    #1;
    chk("reset_idle", 6'b000000, 0, 0, 0, 0);
    set(1, 1, 1, 1, 1, 4);
    chk("reset_masks_req", 6'b000000, 0, 0, 0, 0);
    set(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Priority between concurrent requests.
    set(1, 1, 1, 0, 0, 0); chk("prio_id_ex_mem", 6'b011111, 0, 0, 0, 0);
    set(1, 1, 1, 1, 0, 0); chk("prio_flush",     6'b000000, 1, 0, 0, 0);
    set(1, 1, 0, 0, 0, 0); chk("prio_id_ex",     6'b001111, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0, 0); chk("prio_id",        6'b000111, 0, 0, 0, 0);
    set(0, 0, 0, 0, 0, 0); chk("prio_none",      6'b000000, 0, 0, 0, 0);
    tick();

    // N=4, no interference: cnt 3,2,1,0, done in cycle 4.
    set(0, 0, 0, 0, 1, 4); chk("n4_c1", 6'b001111, 0, 0, 0, 3); tick();
    set(0, 0, 0, 0, 0, 4); chk("n4_c2", 6'b001111, 0, 1, 0, 2); tick();
    chk("n4_c3", 6'b001111, 0, 1, 0, 1); tick();
    chk("n4_c4", 6'b000000, 0, 1, 1, 0); tick();
    chk("n4_idle", 6'b000000, 0, 0, 0, 0); tick();

    // N=4 with mem wait in cycles 2-3: cnt frozen, done moves to cycle 6.
    // A start raised mid-op (cycle 4) must be ignored.
    set(0, 0, 0, 0, 1, 4); chk("mem_c1", 6'b001111, 0, 0, 0, 3); tick();
    set(0, 0, 1, 0, 0, 4); chk("mem_c2", 6'b011111, 0, 1, 0, 2); tick();
    chk("mem_c3", 6'b011111, 0, 1, 0, 2); tick();
    set(0, 0, 0, 0, 1, 9); chk("mem_c4", 6'b001111, 0, 1, 0, 2); tick();
    set(0, 0, 0, 0, 0, 0); chk("mem_c5", 6'b001111, 0, 1, 0, 1); tick();
    chk("mem_c6", 6'b000000, 0, 1, 1, 0); tick();
    chk("mem_idle", 6'b000000, 0, 0, 0, 0); tick();

    // N=6 flushed in cycle 2, then a new N=2 op right after.
    set(0, 0, 0, 0, 1, 6); chk("fl_c1", 6'b001111, 0, 0, 0, 5); tick();
    set(0, 0, 0, 1, 0, 6); chk("fl_c2", 6'b000000, 1, 1, 0, 4); tick();
    set(0, 0, 0, 0, 1, 2); chk("fl_restart", 6'b001111, 0, 0, 0, 1); tick();
    set(0, 0, 0, 0, 0, 0); chk("n2_done", 6'b000000, 0, 1, 1, 0); tick();
    chk("n2_idle", 6'b000000, 0, 0, 0, 0); tick();

    // Single- and zero-cycle ops complete in place.
    set(0, 0, 0, 0, 1, 1); chk("n1", 6'b000000, 0, 0, 1, 0); tick();
    set(0, 0, 0, 0, 1, 0); chk("n0", 6'b000000, 0, 0, 1, 0); tick();
    set(0, 0, 0, 0, 0, 0); chk("n0_idle", 6'b000000, 0, 0, 0, 0); tick();

    // Reset mid-op (N=5, rst in cycle 3): immediate zero, no done later.
    set(0, 0, 0, 0, 1, 5); chk("rst_c1", 6'b001111, 0, 0, 0, 4); tick();
    set(0, 0, 0, 0, 0, 0); chk("rst_c2", 6'b001111, 0, 1, 0, 3); tick();
    rst = 1'b1;
    chk("rst_c3", 6'b000000, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_after_%0d", i), 6'b000000, 0, 0, 0, 0);
      tick();
    end

`ifdef STALL_PERF_EN
    // Clear wins over a same-cycle increment, then count 3 id-stall cycles.
    perf_clr = 1'b1; set(1, 0, 0, 0, 0, 0); tick();
    perf_clr = 1'b0; #2;
    chk_val("perf_clr_wins", perf_stall_cycles, 32'd0);
    tick(); tick(); tick();
    set(0, 0, 0, 0, 0, 0); #2;
    chk_val("perf_stall_3", perf_stall_cycles, 32'd3);
    set(0, 0, 0, 1, 0, 0); tick();
    set(0, 0, 0, 0, 0, 0); #2;
    chk_val("perf_flush_1", {16'd0, perf_flush_cnt}, 32'd1);
    chk_val("perf_stall_hold", perf_stall_cycles, 32'd3);
    perf_clr = 1'b1; tick();
    perf_clr = 1'b0; #2;
    chk_val("perf_stall_clr", perf_stall_cycles, 32'd0);
    chk_val("perf_flush_clr", {16'd0, perf_flush_cnt}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
